// File: rtl/sm2_sign_core.sv
// SM2 signature sequencer: Z_A, e, k*G, r, (1+da)^-1, s, nonce retry.
// Optional Z_A cache keyed on {id, px, py}: define SM2_ZA_CACHE_EN.
module sm2_sign_core #(
  parameter int LEN_M = 112,
  parameter int LEN_ID = 128,
  parameter int MAX_RETRY = 4,
  localparam int LZA = 16 + LEN_ID + 1536,
  localparam int LE = 256 + LEN_M,
  localparam int LMSG = (LZA > LE) ? LZA : LE,
  localparam int CW = $clog2(MAX_RETRY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_M-1:0] M,
  input  logic [LEN_ID-1:0] id,
  input  logic [255:0]     da,
  input  logic [255:0]     px,
  input  logic [255:0]     py,
  input  logic [255:0]     k,
  output logic             k_req,
  input  logic             k_valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [255:0]     o_r,
  output logic [255:0]     o_s,
  output logic             o_sm3_rst_n,
  output logic [LMSG-1:0]  o_sm3_msg,
  output logic [15:0]      o_sm3_len,
  input  logic             i_sm3_done,
  input  logic [255:0]     i_sm3_dig,
  output logic             o_pm_rst_n,
  output logic [255:0]     o_pm_k,
  input  logic             i_pm_done,
  input  logic [255:0]     i_pm_x,
  output logic             o_inv_rst_n,
  output logic [255:0]     o_inv_a,
  input  logic             i_inv_done,
  input  logic [255:0]     i_inv_q,
  output logic             o_bm_rst_n,
  output logic [255:0]     o_bm_a,
  output logic [255:0]     o_bm_b,
  input  logic             i_bm_done,
  input  logic [255:0]     i_bm_p
);

  localparam logic [255:0] N =
    256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFF7203DF6B21C6052B53BBF40939D54123;
  localparam logic [255:0] N1 = N - 256'd1;
  localparam logic [255:0] CA =
    256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFC;
  localparam logic [255:0] CB =
    256'h28E9FA9E9D9F5E344D5A9E4BCF6509A7F39789F515AB8F92DDBCBD414D940E93;
  localparam logic [255:0] GX =
    256'h32C4AE2C1F1981195F9904466A39C9948FE30BBFF2660BE1715A4589334C74C7;
  localparam logic [255:0] GY =
    256'hBC3736A2F4F6779C59BDCEE36B692153D0A9877CC62A474002DF32E52139F0A0;

  typedef enum logic [3:0] {
    S_IDLE, S_ZA, S_E, S_KG, S_R, S_INV, S_RDA,
    S_SUB, S_SMUL, S_SCHK, S_RETRY, S_DONE, S_ERR
  } state_t;

  state_t r_st, w_nx;
  logic r_first;
  logic [CW-1:0] r_cnt;
  logic [LEN_M-1:0] r_m;
  logic [LEN_ID-1:0] r_id;
  logic [255:0] r_da, r_px, r_py, r_k;
  logic [255:0] r_za, r_e, r_x1, r_r;
  logic [255:0] r_inv, r_rda, r_u, r_s;
  logic [255:0] w_r, w_t, w_u;
  logic w_idle, w_acc, w_hit;
  logic w_sm3_ok, w_pm_ok, w_inv_ok, w_bm_ok;

  function automatic logic [255:0] f_add(
    input logic [255:0] a, input logic [255:0] b);
    logic [256:0] t;
    t = {1'b0, a} + {1'b0, b};
    if (t >= {1'b0, N}) t = t - {1'b0, N};
    return t[255:0];
  endfunction

  function automatic logic [255:0] f_sub(
    input logic [255:0] a, input logic [255:0] b);
    return (a >= b) ? a - b : a - b + N;
  endfunction

  assign w_idle = (r_st == S_IDLE) || (r_st == S_DONE) ||
                  (r_st == S_ERR);
  assign w_acc = w_idle && start;
  assign w_r = f_add(r_e, r_x1);
  assign w_t = f_add(w_r, r_k);
  assign w_u = f_sub(r_k, r_rda);

  // A sub-block done is only trusted once its launch cycle is over.
  assign w_sm3_ok = i_sm3_done && !r_first;
  assign w_pm_ok = i_pm_done && !r_first;
  assign w_inv_ok = i_inv_done && !r_first;
  assign w_bm_ok = i_bm_done && !r_first;

`ifdef SM2_ZA_CACHE_EN
  logic [LEN_ID-1:0] r_tag_id;
  logic [255:0] r_tag_px, r_tag_py;
  logic r_tag_v;

  assign w_hit = r_tag_v && (id == r_tag_id) &&
                 (px == r_tag_px) && (py == r_tag_py);

  // Z_A tag: set when Z_A is computed, dropped on error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_v <= 1'b0;
      r_tag_id <= '0;
      r_tag_px <= '0;
      r_tag_py <= '0;
    end else if (w_nx == S_ERR) begin
      r_tag_v <= 1'b0;
    end else if (r_st == S_ZA && w_sm3_ok) begin
      r_tag_v <= 1'b1;
      r_tag_id <= r_id;
      r_tag_px <= r_px;
      r_tag_py <= r_py;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  // State register; r_first marks the first cycle of every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st <= S_IDLE;
      r_first <= 1'b0;
    end else begin
      r_st <= w_nx;
      r_first <= (w_nx != r_st);
    end
  end

  // Next-state decode.
  always_comb begin
    w_nx = r_st;
    case (r_st)
      S_IDLE, S_DONE, S_ERR:
        if (start)
          w_nx = (da == N1) ? S_ERR : (w_hit ? S_E : S_ZA);
      S_ZA: if (w_sm3_ok) w_nx = S_E;
      S_E: if (w_sm3_ok) w_nx = S_KG;
      S_KG: if (w_pm_ok) w_nx = S_R;
      S_R:
        w_nx = (w_r == '0 || w_t == '0) ? S_RETRY : S_INV;
      S_INV: if (w_inv_ok) w_nx = S_RDA;
      S_RDA: if (w_bm_ok) w_nx = S_SUB;
      S_SUB: w_nx = S_SMUL;
      S_SMUL: if (w_bm_ok) w_nx = S_SCHK;
      S_SCHK: w_nx = (r_s == '0) ? S_RETRY : S_DONE;
      S_RETRY:
        if (r_cnt >= CW'(MAX_RETRY)) w_nx = S_ERR;
        else if (k_valid) w_nx = S_KG;
      default: w_nx = S_IDLE;
    endcase
  end

  // Operand latches and per-state results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_m <= '0;
      r_id <= '0;
      r_da <= '0;
      r_px <= '0;
      r_py <= '0;
      r_k <= '0;
      r_za <= '0;
      r_e <= '0;
      r_x1 <= '0;
      r_r <= '0;
      r_inv <= '0;
      r_rda <= '0;
      r_u <= '0;
      r_s <= '0;
    end else begin
      if (w_acc) begin
        r_cnt <= '0;
        r_m <= M;
        r_id <= id;
        r_da <= da;
        r_px <= px;
        r_py <= py;
        r_k <= k;
      end
      if (w_nx == S_RETRY && r_st != S_RETRY)
        r_cnt <= r_cnt + 1'b1;
      if (r_st == S_ZA && w_sm3_ok) r_za <= i_sm3_dig;
      if (r_st == S_E && w_sm3_ok) r_e <= i_sm3_dig;
      if (r_st == S_KG && w_pm_ok) r_x1 <= i_pm_x;
      if (r_st == S_R) r_r <= w_r;
      if (r_st == S_INV && w_inv_ok) r_inv <= i_inv_q;
      if (r_st == S_RDA && w_bm_ok) r_rda <= i_bm_p;
      if (r_st == S_SUB) r_u <= w_u;
      if (r_st == S_SMUL && w_bm_ok) r_s <= i_bm_p;
      if (r_st == S_RETRY && k_req && k_valid) r_k <= k;
    end
  end

  // SM3 message: Z_A preimage in ZA, Z_A||M in E, LSB-aligned.
  always_comb begin
    o_sm3_msg = '0;
    o_sm3_len = 16'(LE);
    if (r_st == S_ZA) begin
      o_sm3_msg = LMSG'({16'(LEN_ID), r_id, CA, CB,
                         GX, GY, r_px, r_py});
      o_sm3_len = 16'(LZA);
    end else if (r_st == S_E) begin
      o_sm3_msg = LMSG'({r_za, r_m});
    end
  end

  assign o_sm3_rst_n = (r_st == S_ZA || r_st == S_E) && !r_first;
  assign o_pm_rst_n = (r_st == S_KG) && !r_first;
  assign o_inv_rst_n = (r_st == S_INV) && !r_first;
  assign o_bm_rst_n = (r_st == S_RDA || r_st == S_SMUL) && !r_first;
  assign o_pm_k = r_k;
  assign o_inv_a = r_da + 256'd1;
  assign o_bm_a = (r_st == S_SMUL) ? r_inv : r_r;
  assign o_bm_b = (r_st == S_SMUL) ? r_u : r_da;

  assign k_req = (r_st == S_RETRY) && (r_cnt < CW'(MAX_RETRY));
  assign busy = !w_idle;
  assign done = (r_st == S_DONE);
  assign err = (r_st == S_ERR);
  assign o_r = done ? r_r : '0;
  assign o_s = done ? r_s : '0;

endmodule

// File: tb/tb_sm2_sign_core.sv
// Bench for sm2_sign_core: behavioural sub-blocks, modular-arithmetic model.
// Covers retry, error, ignored start, mid-run reset and the Z_A cache.
module tb_sm2_sign_core;

  localparam int LEN_M = 112;
  localparam int LEN_ID = 128;
  localparam int LZA = 16 + LEN_ID + 1536;
  localparam int LE = 256 + LEN_M;
  localparam int LMSG = (LZA > LE) ? LZA : LE;
  localparam logic [255:0] N =
    256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFF7203DF6B21C6052B53BBF40939D54123;
  localparam logic [255:0] CA =
    256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFC;
  localparam logic [255:0] CB =
    256'h28E9FA9E9D9F5E344D5A9E4BCF6509A7F39789F515AB8F92DDBCBD414D940E93;
  localparam logic [255:0] GX =
    256'h32C4AE2C1F1981195F9904466A39C9948FE30BBFF2660BE1715A4589334C74C7;
  localparam logic [255:0] GY =
    256'hBC3736A2F4F6779C59BDCEE36B692153D0A9877CC62A474002DF32E52139F0A0;

  logic clk, rst_n, start, k_req, k_valid;
  logic busy, done, err;
  logic [LEN_M-1:0] M;
  logic [LEN_ID-1:0] id;
  logic [255:0] da, px, py, k, o_r, o_s;
  logic sm3_rst_n, sm3_done, pm_rst_n, pm_done;
  logic inv_rst_n, inv_done, bm_rst_n, bm_done;
  logic [LMSG-1:0] sm3_msg;
  logic [15:0] sm3_len;
  logic [255:0] sm3_dig, pm_k, pm_x, inv_a, inv_q;
  logic [255:0] bm_a, bm_b, bm_p;

  int n_chk = 0;
  int n_bad = 0;
  int pm_calls = 0;
  int force_upto = 0;
  int za_cnt = 0;
  int n_launch = 0;
  int sm3_w, pm_w, inv_w, bm_w;
  logic p_sm3 = 1'b0, p_pm = 1'b0, p_inv = 1'b0, p_bm = 1'b0;
  logic [255:0] e_force;
  logic [255:0] kq[$];
  bit saw_kreq;

  sm2_sign_core dut (
    .clk(clk), .rst_n(rst_n), .start(start), .M(M), .id(id),
    .da(da), .px(px), .py(py), .k(k), .k_req(k_req),
    .k_valid(k_valid), .busy(busy), .done(done), .err(err),
    .o_r(o_r), .o_s(o_s),
    .o_sm3_rst_n(sm3_rst_n), .o_sm3_msg(sm3_msg),
    .o_sm3_len(sm3_len), .i_sm3_done(sm3_done),
    .i_sm3_dig(sm3_dig),
    .o_pm_rst_n(pm_rst_n), .o_pm_k(pm_k),
    .i_pm_done(pm_done), .i_pm_x(pm_x),
    .o_inv_rst_n(inv_rst_n), .o_inv_a(inv_a),
    .i_inv_done(inv_done), .i_inv_q(inv_q),
    .o_bm_rst_n(bm_rst_n), .o_bm_a(bm_a), .o_bm_b(bm_b),
    .i_bm_done(bm_done), .i_bm_p(bm_p)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [255:0] madd(
    input logic [255:0] a, input logic [255:0] b);
    logic [511:0] t;
    t = ({256'd0, a} + {256'd0, b}) % {256'd0, N};
    return t[255:0];
  endfunction

  function automatic logic [255:0] msub(
    input logic [255:0] a, input logic [255:0] b);
    logic [511:0] t;
    t = ({256'd0, a} + {256'd0, N} - {256'd0, b}) % {256'd0, N};
    return t[255:0];
  endfunction

  function automatic logic [255:0] mmul(
    input logic [255:0] a, input logic [255:0] b);
    logic [511:0] t;
    t = ({256'd0, a} * {256'd0, b}) % {256'd0, N};
    return t[255:0];
  endfunction

  // Fermat inverse: a^(n-2) mod n.
  function automatic logic [255:0] minv(input logic [255:0] a);
    logic [255:0] res, b, ex;
    res = 256'd1;
    b = a;
    ex = N - 256'd2;
    for (int i = 0; i < 256; i++) begin
      if (ex[i]) res = mmul(res, b);
      b = mmul(b, b);
    end
    return res;
  endfunction

  // Stand-in digest; result kept below n.
  function automatic logic [255:0] fh(
    input logic [2047:0] m, input logic [15:0] len);
    logic [255:0] h;
    h = 256'h6A09E667BB67AE853C6EF372A54FF53A510E527F9B05688C1F83D9AB5BE0CD19;
    for (int i = 0; i < 8; i++)
      h = {h[250:0], h[255:251]} ^ m[i*256 +: 256] ^ (h >> 3);
    h = h ^ {240'd0, len};
    h[255] = 1'b0;
    return h;
  endfunction

  // Stand-in x coordinate of k*G.
  function automatic logic [255:0] pmx(input logic [255:0] kk);
    return madd(mmul(kk, 256'd7), 256'd12345);
  endfunction

  function automatic logic [255:0] rnd();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    v[255] = 1'b0;
    if (v == '0) v = 256'd1;
    return v;
  endfunction

  function automatic void ref_sign(
    input logic [LEN_ID-1:0] fid, input logic [LEN_M-1:0] fm,
    input logic [255:0] fda, input logic [255:0] fpx,
    input logic [255:0] fpy, input logic [255:0] fk,
    output logic [255:0] fe, output logic [255:0] fr,
    output logic [255:0] fs);
    logic [2047:0] zm;
    logic [255:0] za, u;
    zm = '0;
    zm[LZA-1:0] = {16'(LEN_ID), fid, CA, CB, GX, GY, fpx, fpy};
    za = fh(zm, 16'(LZA));
    zm = '0;
    zm[LE-1:0] = {za, fm};
    fe = fh(zm, 16'(LE));
    fr = madd(fe, pmx(fk));
    u = msub(fk, mmul(fr, fda));
    fs = mmul(minv(madd(fda, 256'd1)), u);
  endfunction

  // Behavioural SM3 block.
  always @(posedge clk) begin
    if (!sm3_rst_n) begin
      sm3_done <= 1'b0;
      sm3_dig <= '0;
      sm3_w <= $urandom_range(0, 4);
    end else if (sm3_w > 0) sm3_w <= sm3_w - 1;
    else if (!sm3_done) begin
      sm3_done <= 1'b1;
      sm3_dig <= fh(2048'(sm3_msg), sm3_len);
    end
  end

  // Behavioural point multiply; can be forced to make r+k==n.
  always @(posedge clk) begin
    if (!pm_rst_n) begin
      pm_done <= 1'b0;
      pm_x <= '0;
      pm_w <= $urandom_range(0, 6);
    end else if (pm_w > 0) pm_w <= pm_w - 1;
    else if (!pm_done) begin
      pm_done <= 1'b1;
      pm_calls <= pm_calls + 1;
      if (pm_calls < force_upto)
        pm_x <= msub(msub(256'd0, pm_k), e_force);
      else
        pm_x <= pmx(pm_k);
    end
  end

  // Behavioural modular inverse.
  always @(posedge clk) begin
    if (!inv_rst_n) begin
      inv_done <= 1'b0;
      inv_q <= '0;
      inv_w <= $urandom_range(0, 5);
    end else if (inv_w > 0) inv_w <= inv_w - 1;
    else if (!inv_done) begin
      inv_done <= 1'b1;
      inv_q <= minv(inv_a);
    end
  end

  // Behavioural modular multiply.
  always @(posedge clk) begin
    if (!bm_rst_n) begin
      bm_done <= 1'b0;
      bm_p <= '0;
      bm_w <= $urandom_range(0, 3);
    end else if (bm_w > 0) bm_w <= bm_w - 1;
    else if (!bm_done) begin
      bm_done <= 1'b1;
      bm_p <= mmul(bm_a, bm_b);
    end
  end

  // Launch counters (rising edge of each sub-block rst).
  always @(posedge clk) begin
    p_sm3 <= sm3_rst_n;
    p_pm <= pm_rst_n;
    p_inv <= inv_rst_n;
    p_bm <= bm_rst_n;
    n_launch <= n_launch + int'(sm3_rst_n && !p_sm3) +
                int'(pm_rst_n && !p_pm) +
                int'(inv_rst_n && !p_inv) + int'(bm_rst_n && !p_bm);
    if (sm3_rst_n && !p_sm3 && sm3_len == 16'(LZA))
      za_cnt <= za_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic chk_res(input logic [255:0] er,
                         input logic [255:0] es);
    chk("done", done, 1);
    chk("err", err, 0);
    chk("busy", busy, 0);
    chk("r", o_r, er);
    chk("s", o_s, es);
  endtask

  // One operation: pulse start, serve k_req from kq, wait done/err.
  task automatic go(input bit hold, input logic [255:0] hk,
                    input bit poke);
    bit fin, poked;
    fin = 0;
    poked = 0;
    saw_kreq = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (hold) begin
      k_valid = 1'b1;
      k = hk;
    end
    for (int c = 0; c < 800 && !fin; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done || err) fin = 1;
      else begin
        if (k_req) saw_kreq = 1;
        if (poke && !poked && pm_rst_n) begin
          start = 1'b1;
          M = ~M;
          da = da ^ 256'd2;
          poked = 1;
        end
        if (k_req && kq.size() > 0) begin
          k_valid = 1'b1;
          k = kq.pop_front();
        end else if (!hold) k_valid = 1'b0;
      end
    end
    k_valid = 1'b0;
    chk("finish", fin, 1);
  endtask

  task automatic rnd_in();
    logic [255:0] v;
    v = rnd();
    id = v[LEN_ID-1:0];
    v = rnd();
    M = v[LEN_M-1:0];
    da = rnd();
    px = rnd();
    py = rnd();
    k = rnd();
  endtask

  initial begin
    logic [255:0] e, r, s, kb;
    int lc, zc;
    bit seen;
    rst_n = 1'b0;
    start = 1'b0;
    k_valid = 1'b0;
    rnd_in();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_kreq", k_req, 0);
    chk("rst_r", o_r, 0);
    chk("rst_s", o_s, 0);
    chk("rst_subs", {sm3_rst_n, pm_rst_n, inv_rst_n, bm_rst_n}, 0);
    rst_n = 1'b1;

    id = 128'h31323334353637383132333435363738;
    M = 112'h6D65737361676520646967657374;
    da = 256'h3945208F7B2144B13F36E38AC6D39F95889393692860B51A42FB81EF4DF7C5B8;
    px = 256'h09F9DF311E5421A150DD7D161E4BC5C672179FAD1833FC076BB08FF356F35020;
    py = 256'hCCEA490CE26775A52DC6EA718CC1AA600AED05FBF35E084A6632F6072DA9AD13;
    k = 256'h59276E27D506861A16680F3AD9C02DCCEF3CC1FA3CDBE4CE6D54B80DEAC1BC21;
    ref_sign(id, M, da, px, py, k, e, r, s);
    go(0, '0, 0);
    chk_res(r, s);

    for (int i = 0; i < 4; i++) begin
      rnd_in();
      ref_sign(id, M, da, px, py, k, e, r, s);
      go(i[0], rnd(), 0);
      chk_res(r, s);
    end

    rnd_in();
    kb = rnd();
    ref_sign(id, M, da, px, py, kb, e, r, s);
    e_force = e;
    force_upto = pm_calls + 1;
    kq.push_back(kb);
    go(0, '0, 0);
    chk("retry_kreq", saw_kreq, 1);
    chk_res(r, s);

    rnd_in();
    kb = rnd();
    ref_sign(id, M, da, px, py, kb, e, r, s);
    e_force = e;
    force_upto = pm_calls + 1;
    go(1, kb, 0);
    chk("same_cyc_kreq", saw_kreq, 1);
    chk_res(r, s);

    rnd_in();
    ref_sign(id, M, da, px, py, k, e, r, s);
    e_force = e;
    force_upto = pm_calls + 4;
    for (int i = 0; i < 3; i++) kq.push_back(rnd());
    go(0, '0, 0);
    chk("exh_err", err, 1);
    chk("exh_done", done, 0);
    chk("exh_r", o_r, 0);
    chk("exh_s", o_s, 0);
    chk("exh_busy", busy, 0);
    chk("exh_kreq", k_req, 0);
    chk("exh_kq", kq.size(), 0);
    force_upto = pm_calls;

    rnd_in();
    da = N - 256'd1;
    lc = n_launch;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("dan1_err", err, 1);
    @(negedge clk);
    chk("dan1_err2", err, 1);
    chk("dan1_busy", busy, 0);
    chk("dan1_launch", n_launch - lc, 0);

    rnd_in();
    ref_sign(id, M, da, px, py, k, e, r, s);
    go(0, '0, 1);
    chk_res(r, s);

    rnd_in();
    seen = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 800 && !seen; c++) begin
      @(negedge clk);
      if (inv_rst_n) seen = 1;
    end
    chk("inv_reached", seen, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_flags", {done, err, k_req}, 0);
    chk("mrst_r", o_r, 0);
    chk("mrst_s", o_s, 0);
    chk("mrst_subs", {sm3_rst_n, pm_rst_n, inv_rst_n, bm_rst_n}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    rnd_in();
    ref_sign(id, M, da, px, py, k, e, r, s);
    zc = za_cnt;
    go(0, '0, 0);
    chk_res(r, s);
    chk("za_first", za_cnt - zc, 1);
    begin
      logic [255:0] v;
      v = rnd();
      M = v[LEN_M-1:0];
    end
    da = rnd();
    k = rnd();
    ref_sign(id, M, da, px, py, k, e, r, s);
    zc = za_cnt;
    go(0, '0, 0);
    chk_res(r, s);
`ifdef SM2_ZA_CACHE_EN
    chk("za_hit", za_cnt - zc, 0);
`else
    chk("za_rerun", za_cnt - zc, 1);
`endif
    px = rnd();
    ref_sign(id, M, da, px, py, k, e, r, s);
    zc = za_cnt;
    go(0, '0, 0);
    chk_res(r, s);
    chk("za_newpx", za_cnt - zc, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
